// File: rtl/percep_arb_pkg.sv
// Shared encodings and default timing limits for the ydx memory arbiter.
package percep_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_H = 2'b01,
        GNT_E = 2'b10
    } arb_state_e;

    localparam logic REQ_H = 1'b0;
    localparam logic REQ_E = 1'b1;

    localparam int unsigned QUANTUM_DEF  = 8;
    localparam int unsigned LOCK_MAX_DEF = 32;

    function automatic arb_state_e other_grant(input arb_state_e st);
        case (st)
            GNT_H:   other_grant = GNT_E;
            GNT_E:   other_grant = GNT_H;
            default: other_grant = IDLE;
        endcase
    endfunction

endpackage

// File: rtl/percep_arb_cnt.sv
// Saturating up-counter with synchronous clear; flags when it sits at MAX.
module percep_arb_cnt #(
    parameter int unsigned MAX = 7,
    parameter int unsigned W   = (MAX > 0) ? $clog2(MAX + 1) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic sat_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear has priority over the increment; the count holds at MAX.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != W'(MAX))) begin
            cnt_d = cnt_q + W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_o = (cnt_q == W'(MAX));

endmodule

// File: rtl/percep_mem_arb.sv
// Round-robin, quantum-limited arbiter with burst lock and lock watchdog,
// sharing the single-port ydx memory between the host loader and the engine.
module percep_mem_arb
    import percep_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned DATA_W   = 17,
    parameter int unsigned QUANTUM  = QUANTUM_DEF,
    parameter int unsigned LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_h,
    input  logic              we_h,
    input  logic [ADDR_W-1:0] addr_h,
    input  logic [DATA_W-1:0] wdata_h,
    input  logic              lock_h,
    input  logic              req_e,
    input  logic [ADDR_W-1:0] addr_e,
    input  logic              lock_e,
    output logic              gnt_h,
    output logic              gnt_e,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid_h,
    output logic              rvalid_e,
    output logic              lock_err,
    output logic              mem_cs,
    output logic              mem_we,
    output logic              mem_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e state_q, state_d;
    logic       last_q, last_d;
    logic       lock_err_q, lock_err_d;
    logic       rvalid_h_q, rvalid_h_d;
    logic       rvalid_e_q, rvalid_e_d;
    logic       own_req_s, own_lock_s, oth_req_s, own_id_s;
    logic       granted_s, grant_chg_s;
    logic       quant_sat_s, lock_sat_s;

    // Owner-relative view of the request lines.
    always_comb begin
        own_req_s  = 1'b0;
        own_lock_s = 1'b0;
        oth_req_s  = 1'b0;
        own_id_s   = REQ_H;
        case (state_q)
            GNT_H: begin
                own_req_s  = req_h;
                own_lock_s = lock_h;
                oth_req_s  = req_e;
                own_id_s   = REQ_H;
            end
            GNT_E: begin
                own_req_s  = req_e;
                own_lock_s = lock_e;
                oth_req_s  = req_h;
                own_id_s   = REQ_E;
            end
            default: begin
                own_req_s  = 1'b0;
                own_lock_s = 1'b0;
                oth_req_s  = 1'b0;
                own_id_s   = REQ_H;
            end
        endcase
    end

    assign granted_s   = (state_q == GNT_H) || (state_q == GNT_E);
    assign grant_chg_s = (state_d != state_q);

    percep_arb_cnt #(.MAX(QUANTUM - 1)) u_quant_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (grant_chg_s | ~granted_s),
        .en_i  (granted_s),
        .sat_o (quant_sat_s)
    );

    // sat means LOCK_MAX-1 earlier lock-high cycles, so a high lock now is the limit.
    percep_arb_cnt #(.MAX(LOCK_MAX - 1)) u_lock_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (grant_chg_s | ~own_lock_s),
        .en_i  (own_lock_s),
        .sat_o (lock_sat_s)
    );

    // Next-state: tie-break in IDLE, then watchdog > release > quantum preemption.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        lock_err_d = lock_err_q;
        case (state_q)
            IDLE: begin
                if (req_h && req_e) begin
                    state_d = (last_q == REQ_H) ? GNT_E : GNT_H;
                end else if (req_h) begin
                    state_d = GNT_H;
                end else if (req_e) begin
                    state_d = GNT_E;
                end else begin
                    state_d = IDLE;
                end
            end
            GNT_H, GNT_E: begin
                if (own_lock_s && lock_sat_s) begin
                    lock_err_d = 1'b1;
                    state_d    = oth_req_s ? other_grant(state_q) : IDLE;
                    last_d     = own_id_s;
                end else if (!own_req_s && !own_lock_s) begin
                    state_d = oth_req_s ? other_grant(state_q) : IDLE;
                    last_d  = own_id_s;
                end else if (!own_lock_s && oth_req_s && quant_sat_s) begin
                    state_d = other_grant(state_q);
                    last_d  = own_id_s;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory pin mux; an access needs both the grant and a live request.
    always_comb begin
        mem_cs     = 1'b0;
        mem_we     = 1'b0;
        mem_oe     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        rvalid_h_d = 1'b0;
        rvalid_e_d = 1'b0;
        if ((state_q == GNT_H) && req_h) begin
            mem_cs     = 1'b1;
            mem_we     = we_h;
            mem_oe     = ~we_h;
            mem_addr   = addr_h;
            mem_wdata  = wdata_h;
            rvalid_h_d = ~we_h;
        end else if ((state_q == GNT_E) && req_e) begin
            mem_cs     = 1'b1;
            mem_oe     = 1'b1;
            mem_addr   = addr_e;
            rvalid_e_d = 1'b1;
        end else begin
            mem_cs = 1'b0;
        end
    end

    // State, round-robin pointer, sticky error and read-return tags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_q     <= REQ_E;
            lock_err_q <= 1'b0;
            rvalid_h_q <= 1'b0;
            rvalid_e_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            lock_err_q <= lock_err_d;
            rvalid_h_q <= rvalid_h_d;
            rvalid_e_q <= rvalid_e_d;
        end
    end

    assign gnt_h    = (state_q == GNT_H);
    assign gnt_e    = (state_q == GNT_E);
    assign rvalid_h = rvalid_h_q;
    assign rvalid_e = rvalid_e_q;
    assign lock_err = lock_err_q;
    assign rdata    = (rvalid_h_q || rvalid_e_q) ? mem_rdata : '0;

endmodule

// File: doc/percep_mem_arb.md
Name: percep_mem_arb

Overview:
Arbiter for the single-port ydx memory, shared by two requesters: the host loader (H, read/write) and the inference engine (E, read-only). It grants one owner at a time. Arbitration is round-robin with a time quantum. An owner may lock the memory for a burst, such as reading the x0..x4 group of one sample. A watchdog guards against a stuck lock. The block sits between the requesters and the memory cs/we/oe/addr/data pins.

Parameters:
ADDR_W, 7, memory address width
DATA_W, 17, memory data width (yd + 16-bit fp)
QUANTUM, 8, max consecutive granted cycles before preemption when the other requester waits and lock is low
LOCK_MAX, 32, max consecutive cycles lock may stay high before forced release

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_h  in  1  host request; held until done
we_h  in  1  host write (1) / read (0), valid with req_h
addr_h  in  ADDR_W  host address
wdata_h  in  DATA_W  host write data
lock_h  in  1  host burst lock
req_e  in  1  engine request (read only)
addr_e  in  ADDR_W  engine address
lock_e  in  1  engine burst lock
gnt_h  out  1  host owns memory this cycle
gnt_e  out  1  engine owns memory this cycle
rdata  out  DATA_W  read data, shared return bus
rvalid_h  out  1  rdata belongs to host
rvalid_e  out  1  rdata belongs to engine
lock_err  out  1  sticky: watchdog forced a release
mem_cs  out  1  memory chip enable
mem_we  out  1  memory write enable
mem_oe  out  1  memory read enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, 1-cycle synchronous read

Behaviour:
- Reset (async, rst_n=0): state=IDLE, all gnt/rvalid/mem_* outputs = 0, lock_err = 0, counters = 0, rr pointer = E-last (host wins the first tie).
- States: IDLE, GNT_H, GNT_E. The state is registered. gnt_h = (state==GNT_H); gnt_e = (state==GNT_E).
- IDLE transitions:
  - only req_h -> GNT_H
  - only req_e -> GNT_E
  - both -> the requester that was not last owner
  - A grant appears one cycle after the request is first seen; no access happens in IDLE.
- An access occurs in any cycle where gnt_x=1 and req_x=1:
  - mem_cs = 1, mem_addr = addr_x.
  - Host: mem_we = we_h, mem_oe = ~we_h, mem_wdata = wdata_h.
  - Engine: mem_we = 0, mem_oe = 1.
  - When gnt_x=1 but req_x=0, all mem_* = 0.
- Read return: rdata = mem_rdata. rvalid_x is asserted exactly one cycle after the accepted read of x. It is still delivered if the grant has already moved on.
- Leaving GNT_x (evaluated every cycle; precedence in order):
  1. Watchdog: lock_x high for LOCK_MAX consecutive granted cycles -> set lock_err, release as in rule 2.
  2. If req_x=0 and lock_x=0 -> go to the other grant if it is requesting, else IDLE. Update the rr pointer to x.
  3. If lock_x=0, the other requester is requesting, and the quantum counter reaches QUANTUM-1 -> switch to the other grant. Update the rr pointer to x.
  4. Otherwise stay.
- Counters:
  - The quantum counter counts granted cycles of the current owner and clears on every grant change.
  - The lock counter counts consecutive lock-high cycles of the current owner. It clears when lock drops or the grant changes.
  - Both counters saturate and never wrap.
- Locked release with req low: while lock_x=1 and req_x=0, the grant is held (idle cycles; the other requester waits).
- The switch between owners takes no IDLE bubble: GNT_H -> GNT_E happens directly, and the new owner may access in the first granted cycle.
- lock_err clears only on reset.
- Reset mid-burst: outputs drop immediately; pending rvalid is discarded.

Decomposition:
- Package percep_arb_pkg holds:
  - state encodings IDLE=2'b00, GNT_H=2'b01, GNT_E=2'b10
  - requester IDs REQ_H=1'b0, REQ_E=1'b1
  - defaults for QUANTUM and LOCK_MAX
- Sub-module percep_arb_cnt: a saturating counter with clear and enable. It is instantiated twice, for the quantum and lock counters. The mux and FSM stay in the top module.

Test Plan:
- Single host write burst: req_h=1, we_h=1, addr_h=0..4 -> gnt_h is 1 from cycle 1, mem_we=1 with mem_addr 0..4 on consecutive cycles, then state returns to IDLE with gnt_h=0.
- Simultaneous first requests: req_h=req_e=1 after reset -> gnt_h first. With lock low and QUANTUM=8, gnt_e follows after 8 host cycles with no bubble.
- Engine locked 5-word read: lock_e=1, addr_e=0..4 while req_h=1 for more than QUANTUM cycles -> no preemption. rvalid_e pulses on 5 consecutive cycles, each one cycle after its read. gnt_h arrives the cycle after lock_e and req_e drop.
- Stuck lock: lock_e=1 for 40 cycles with LOCK_MAX=32 -> release after 32 cycles, lock_err=1 and stays 1, gnt_h asserted.
- In-flight read across a grant switch: the engine's last read is issued in its final granted cycle -> rvalid_e=1 in the host's first granted cycle, rvalid_h=0.
- Reset mid-access: rst_n pulsed low during GNT_E -> all outputs are 0 asynchronously, and after release the next tie goes to host.
